// File: rtl/ifmap_row_tagger_if.sv
// Pixel stream in, tagged IF buffer words out.
// The tagger sits on the slave side; the driver of the pixel stream and
// owner of the IF buffer sits on the master side.
interface ifmap_row_tagger_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  pix_valid;
    logic [DATA_WIDTH-1:0] pix_data;
    logic                  pix_ready;
    logic                  if_full;
    logic                  if_wen;
    logic [DATA_WIDTH+1:0] if_din;

    modport master (
        output pix_valid, pix_data, if_full,
        input  pix_ready, if_wen, if_din
    );

    modport slave (
        input  pix_valid, pix_data, if_full,
        output pix_ready, if_wen, if_din
    );
endinterface

// File: rtl/ifmap_row_tagger.sv
// ifmap_row_tagger: counts pixels per row and rows per frame, tags each pixel
// with start/end-of-row flags and writes it to the IF buffer through a
// two-entry output stage (A drives the buffer, B is the skid entry).
//
// state  | meaning
// IDLE   | waiting for start; config errors reported here
// STREAM | accepting pixels until row_len*num_rows have arrived
// DRAIN  | all pixels accepted; waiting for A and B to empty
module ifmap_row_tagger #(
    parameter int DATA_WIDTH = 16,
    parameter int ROW_LEN_W  = 8,
    parameter int ROW_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ROW_LEN_W-1:0] cfg_row_len,
    input  logic [ROW_CNT_W-1:0] cfg_num_rows,
    ifmap_row_tagger_if.slave    bus,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);
    localparam int WORD_W = DATA_WIDTH + 2;
    localparam logic [ROW_LEN_W-1:0] LEN_ONE = ROW_LEN_W'(1);
    localparam logic [ROW_CNT_W-1:0] CNT_ONE = ROW_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ROW_LEN_W-1:0] r_row_len;
    logic [ROW_CNT_W-1:0] r_num_rows;
    logic [ROW_LEN_W-1:0] r_col;
    logic [ROW_CNT_W-1:0] r_row;

    logic              r_a_valid;
    logic [WORD_W-1:0] r_a_data;
    logic              r_b_valid;
    logic [WORD_W-1:0] r_b_data;
    logic              r_pix_ready;
    logic              r_done;
    logic              r_cfg_err;

    logic              w_accept;
    logic              w_write;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_frame_last;
    logic              w_start_ok;
    logic              w_cfg_bad;
    logic [WORD_W-1:0] w_word;
    logic              w_a_valid_nxt;
    logic [WORD_W-1:0] w_a_data_nxt;
    logic              w_b_valid_nxt;
    logic [WORD_W-1:0] w_b_data_nxt;
    logic              w_done_nxt;

    assign w_accept     = bus.pix_valid & r_pix_ready;
    assign w_write      = r_a_valid & ~bus.if_full;
    assign w_col_last   = (r_col == r_row_len - LEN_ONE);
    assign w_row_last   = (r_row == r_num_rows - CNT_ONE);
    assign w_frame_last = w_accept & w_col_last & w_row_last;
    // The done cycle already reads as IDLE, but a start there is not honoured.
    assign w_start_ok   = start & (r_state == S_IDLE) & ~r_done;
    assign w_cfg_bad    = (cfg_row_len == '0) | (cfg_num_rows == '0);
    assign w_word       = {(r_col == '0), w_col_last, bus.pix_data};

    // Output stage: oldest word always sits in A; B only fills while A is stuck.
    always_comb begin
        w_a_valid_nxt = r_a_valid;
        w_a_data_nxt  = r_a_data;
        w_b_valid_nxt = r_b_valid;
        w_b_data_nxt  = r_b_data;
        if (w_write && r_b_valid) begin
            w_a_valid_nxt = 1'b1;
            w_a_data_nxt  = r_b_data;
            w_b_valid_nxt = w_accept;
            if (w_accept) begin
                w_b_data_nxt = w_word;
            end
        end else if (w_write || !r_a_valid) begin
            w_a_valid_nxt = w_accept;
            if (w_accept) begin
                w_a_data_nxt = w_word;
            end
        end else if (w_accept) begin
            w_b_valid_nxt = 1'b1;
            w_b_data_nxt  = w_word;
        end
    end

    // Next-state logic and the done condition for the sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok && !w_cfg_bad) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_frame_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!w_a_valid_nxt && !w_b_valid_nxt) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_valid <= 1'b0;
            r_a_data  <= '0;
            r_b_valid <= 1'b0;
            r_b_data  <= '0;
        end else begin
            r_a_valid <= w_a_valid_nxt;
            r_a_data  <= w_a_data_nxt;
            r_b_valid <= w_b_valid_nxt;
            r_b_data  <= w_b_data_nxt;
        end
    end

    // Configuration latch plus column/row counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_len  <= '0;
            r_num_rows <= '0;
            r_col      <= '0;
            r_row      <= '0;
        end else if (w_start_ok && !w_cfg_bad) begin
            r_row_len  <= cfg_row_len;
            r_num_rows <= cfg_num_rows;
            r_col      <= '0;
            r_row      <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= r_row + CNT_ONE;
            end else begin
                r_col <= r_col + LEN_ONE;
            end
        end
    end

    // Registered handshake and status pulses; ready only while B will be empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_ready <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_pix_ready <= (w_state_nxt == S_STREAM) & ~w_b_valid_nxt;
            r_done      <= w_done_nxt;
            r_cfg_err   <= w_start_ok & w_cfg_bad;
        end
    end

    assign bus.pix_ready = r_pix_ready;
    assign bus.if_wen    = w_write;
    assign bus.if_din    = r_a_data;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign cfg_err       = r_cfg_err;
endmodule
